// File: rtl/sev_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sev_seg_pkg
//  Purpose  : Shared types, constants and helpers for the multiplexed
//             seven-segment scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
package sev_seg_pkg;

    // One segment pattern: bit0=a .. bit6=g, bit7=dp, all active-low
    typedef logic [7:0] seg_t;

    // All segments dark
    localparam seg_t SEG_OFF = 8'hFF;

    // Hex digit to active-low segment pattern; entry n occupies bits [8n+7:8n].
    // The dp bit (bit7) is 1 (off) in every entry and is overridden by the decoder.
    localparam logic [127:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Ceiling log2, never less than 1 so it can size a counter directly
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_sev_seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_sev_seg
//  Purpose  : Combinational nibble + decimal point to active-low segment
//             pattern decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_to_sev_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output seg_t       o_seg
);

    // Table lookup for a..g, then place the active-low decimal point
    always_comb begin
        o_seg    = HEX_SEG_TABLE[{i_nibble, 3'b000} +: 8];
        o_seg[7] = ~i_dp;
    end

endmodule
`default_nettype wire

// File: rtl/sev_seg_scan_n.sv
`default_nettype none
// ============================================================================
//  Module   : sev_seg_scan_n
//  Purpose  : Parametrised multiplexed seven-segment scanner with per-digit
//             enable, decimal points, leading-zero blanking and frame-
//             synchronous double-buffered input data.
//  Revision : 1.0 - initial release
// ============================================================================
module sev_seg_scan_n
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk_main,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb,
    input  logic                    load,
    output logic [7:0]              sev_seg_leds,
    output logic [NUM_DIGITS-1:0]   led_an_n,
    output logic                    frame_done
);

    localparam int                  c_IDX_W    = clog2(NUM_DIGITS);
    localparam int                  c_PCNT_W   = clog2(CLK_DIV);
    localparam logic [c_IDX_W-1:0]  c_IDX_MAX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(CLK_DIV - 1);
    // One bit wider so CLK_DIV itself fits when there are no blank cycles
    localparam logic [c_PCNT_W:0]   c_LIT_END  = (c_PCNT_W + 1)'(CLK_DIV - BLANK_CYCLES);

    // Scan state
    logic [c_PCNT_W-1:0]     r_pcnt_q, w_pcnt_d;
    logic [c_IDX_W-1:0]      r_idx_q,  w_idx_d;

    // Pending (written by load) and display (updated at frame boundary) buffers
    logic [4*NUM_DIGITS-1:0] r_pend_data_q, w_pend_data_d;
    logic [NUM_DIGITS-1:0]   r_pend_en_q,   w_pend_en_d;
    logic [NUM_DIGITS-1:0]   r_pend_dp_q,   w_pend_dp_d;
    logic                    r_pend_lzb_q,  w_pend_lzb_d;
    logic [4*NUM_DIGITS-1:0] r_disp_data_q, w_disp_data_d;
    logic [NUM_DIGITS-1:0]   r_disp_en_q,   w_disp_en_d;
    logic [NUM_DIGITS-1:0]   r_disp_dp_q,   w_disp_dp_d;
    logic                    r_disp_lzb_q,  w_disp_lzb_d;

    // Output registers
    seg_t                    r_seg_q, w_seg_d;
    logic [NUM_DIGITS-1:0]   r_an_q,  w_an_d;
    logic                    r_frame_done_q, w_frame_done_d;

    // Combinational helpers
    logic                    w_pcnt_wrap;
    logic                    w_boundary;
    logic                    w_on_window;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_zero_run;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic                    w_cur_lit;
    seg_t                    w_dec_seg;

    assign sev_seg_leds = r_seg_q;
    assign led_an_n     = r_an_q;
    assign frame_done   = r_frame_done_q;

    // Leading-zero blanking: walk from the top digit down; enabled non-zero digits end the run
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_blank[i] = r_disp_lzb_q & w_zero_run & (r_disp_data_q[4*i +: 4] == 4'h0);
            if (r_disp_en_q[i] && (r_disp_data_q[4*i +: 4] != 4'h0)) w_zero_run = 1'b0;
        end
    end

    // Select the nibble, dp and lit status of the digit in the current slot
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_dp  = 1'b0;
        w_cur_lit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx_q == c_IDX_W'(i)) begin
                w_cur_nib = r_disp_data_q[4*i +: 4];
                w_cur_dp  = r_disp_dp_q[i];
                w_cur_lit = r_disp_en_q[i] & ~w_blank[i];
            end
        end
    end

    hex_to_sev_seg u_dec (
        .i_nibble (w_cur_nib),
        .i_dp     (w_cur_dp),
        .o_seg    (w_dec_seg)
    );

    // Next-state: prescaler, digit index, buffers and registered outputs
    always_comb begin
        w_pcnt_wrap = (r_pcnt_q == c_PCNT_MAX);
        w_boundary  = w_pcnt_wrap && (r_idx_q == c_IDX_MAX);
        w_on_window = w_cur_lit && ({1'b0, r_pcnt_q} < c_LIT_END);

        w_pcnt_d = w_pcnt_wrap ? '0 : r_pcnt_q + c_PCNT_W'(1);
        w_idx_d  = r_idx_q;
        if (w_pcnt_wrap) w_idx_d = (r_idx_q == c_IDX_MAX) ? '0 : r_idx_q + c_IDX_W'(1);

        w_pend_data_d = r_pend_data_q;
        w_pend_en_d   = r_pend_en_q;
        w_pend_dp_d   = r_pend_dp_q;
        w_pend_lzb_d  = r_pend_lzb_q;
        if (load) begin
            w_pend_data_d = digit_data;
            w_pend_en_d   = digit_en;
            w_pend_dp_d   = dp_in;
            w_pend_lzb_d  = lzb;
        end

        // Display always takes the pre-edge pending value, so a load on the
        // boundary cycle is shown one frame later
        w_disp_data_d = r_disp_data_q;
        w_disp_en_d   = r_disp_en_q;
        w_disp_dp_d   = r_disp_dp_q;
        w_disp_lzb_d  = r_disp_lzb_q;
        if (w_boundary) begin
            w_disp_data_d = r_pend_data_q;
            w_disp_en_d   = r_pend_en_q;
            w_disp_dp_d   = r_pend_dp_q;
            w_disp_lzb_d  = r_pend_lzb_q;
        end

        w_an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx_q == c_IDX_W'(i)) w_an_d[i] = ~w_on_window;
        end
        w_seg_d        = w_on_window ? w_dec_seg : SEG_OFF;
        w_frame_done_d = w_boundary;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_pcnt_q       <= '0;
            r_idx_q        <= '0;
            r_pend_data_q  <= '0;
            r_pend_en_q    <= '0;
            r_pend_dp_q    <= '0;
            r_pend_lzb_q   <= 1'b0;
            r_disp_data_q  <= '0;
            r_disp_en_q    <= '0;
            r_disp_dp_q    <= '0;
            r_disp_lzb_q   <= 1'b0;
            r_seg_q        <= SEG_OFF;
            r_an_q         <= '1;
            r_frame_done_q <= 1'b0;
        end else begin
            r_pcnt_q       <= w_pcnt_d;
            r_idx_q        <= w_idx_d;
            r_pend_data_q  <= w_pend_data_d;
            r_pend_en_q    <= w_pend_en_d;
            r_pend_dp_q    <= w_pend_dp_d;
            r_pend_lzb_q   <= w_pend_lzb_d;
            r_disp_data_q  <= w_disp_data_d;
            r_disp_en_q    <= w_disp_en_d;
            r_disp_dp_q    <= w_disp_dp_d;
            r_disp_lzb_q   <= w_disp_lzb_d;
            r_seg_q        <= w_seg_d;
            r_an_q         <= w_an_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_scan_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sev_seg_scan_n
//  Purpose  : Directed self-checking bench for sev_seg_scan_n with
//             4 digits, 4 clocks per slot and 1 blank cycle per slot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sev_seg_scan_n;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  digit_en   = '0;
    logic [3:0]  dp_in      = '0;
    logic        lzb  = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  sev_seg_leds;
    logic [3:0]  led_an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk_main = ~clk_main;

    sev_seg_scan_n #(
        .NUM_DIGITS   (4),
        .CLK_DIV      (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk_main     (clk_main),
        .reset        (reset),
        .digit_data   (digit_data),
        .digit_en     (digit_en),
        .dp_in        (dp_in),
        .lzb          (lzb),
        .load         (load),
        .sev_seg_leds (sev_seg_leds),
        .led_an_n     (led_an_n),
        .frame_done   (frame_done)
    );

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %h expected %h", tag, k, got, exp);
        end
    endtask

    // Runs nticks edges of a frame starting right after a boundary (or reset
    // release). s3..s0 are the expected lit patterns per digit (FF = dark).
    // Outputs lag the scan state by one edge; the last slot cycle is blank.
    // A load pulse is issued at scan state load_at (-1 for none).
    task automatic check_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                               input logic [7:0] s1, input logic [7:0] s0,
                               input int load_at, input int nticks);
        logic [7:0] segs [4];
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        int         d;
        int         pc;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int k = 1; k <= nticks; k++) begin
            if (k - 1 == load_at) load = 1'b1;
            tick();
            load    = 1'b0;
            d       = (k - 1) / 4;
            pc      = (k - 1) % 4;
            exp_seg = (pc < 3) ? segs[d] : 8'hFF;
            exp_an  = (pc < 3 && segs[d] != 8'hFF) ? 4'(~(4'b0001 << d)) : 4'hF;
            chk({tag, ".seg"}, k, sev_seg_leds, exp_seg);
            chk({tag, ".an"},  k, {4'h0, led_an_n}, {4'h0, exp_an});
            chk({tag, ".fd"},  k, {7'h0, frame_done}, (k == 16) ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        // Reset held for three edges
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("rst.seg", r, sev_seg_leds, 8'hFF);
            chk("rst.an",  r, {4'h0, led_an_n}, 8'h0F);
            chk("rst.fd",  r, {7'h0, frame_done}, 8'h00);
        end
        reset = 1'b0;

        // Idle frame stays dark; load 0038 for the next frame
        digit_data = 16'h0038; digit_en = 4'hF; dp_in = 4'h0; lzb = 1'b0;
        check_frame("idle", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5, 16);

        // Basic scan; queue the same data with blanking
        lzb = 1'b1;
        check_frame("scan", 8'hC0, 8'hC0, 8'hB0, 8'h80, 5, 16);

        // Leading zeros of 0038 blanked; queue all zeros
        digit_data = 16'h0000;
        check_frame("lzb38", 8'hFF, 8'hFF, 8'hB0, 8'h80, 5, 16);

        // All zeros: only digit 0 shows; queue 0503 with digit 2 disabled
        digit_data = 16'h0503; digit_en = 4'b1011;
        check_frame("lzb0", 8'hFF, 8'hFF, 8'hFF, 8'hC0, 5, 16);

        // Disabled non-zero digit does not end the zero run; queue 1020
        digit_data = 16'h1020; digit_en = 4'hF;
        check_frame("lzbdis", 8'hFF, 8'hFF, 8'hFF, 8'hB0, 5, 16);

        // Inner zeros stay lit; mid-frame load of 00F1 must not tear
        digit_data = 16'h00F1; lzb = 1'b0;
        check_frame("lzbmid", 8'hF9, 8'hC0, 8'hA4, 8'hC0, 7, 16);

        // New data shown; load on the boundary cycle
        digit_data = 16'h1234; dp_in = 4'b0010; digit_en = 4'b1101;
        check_frame("upd", 8'hC0, 8'hC0, 8'h8E, 8'hF9, 15, 16);

        // Boundary load not yet visible
        check_frame("bnd_old", 8'hC0, 8'hC0, 8'h8E, 8'hF9, -1, 16);

        // Digit 1 disabled despite dp; queue all enabled
        digit_en = 4'hF;
        check_frame("dp_dis", 8'hF9, 8'hA4, 8'hFF, 8'h99, 5, 16);

        // Digit 1 with dp lit; pending gets 7777 then reset while digit 2 lit
        digit_data = 16'h7777;
        check_frame("dp_en", 8'hF9, 8'hA4, 8'h30, 8'h99, 2, 9);

        reset = 1'b1;
        tick();
        chk("mrst.seg", 0, sev_seg_leds, 8'hFF);
        chk("mrst.an",  0, {4'h0, led_an_n}, 8'h0F);
        chk("mrst.fd",  0, {7'h0, frame_done}, 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // Display and pending both cleared: two dark frames, index restarted
        check_frame("rst_dark1", 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 16);
        check_frame("rst_dark2", 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
